// File: rtl/iir_coef_sequencer_if.sv
// rtl/iir_coef_sequencer_if.sv - host-side and filter-side signal bundle for the biquad coefficient sequencer
// Optional readback signals exist only when COEF_READBACK_EN is defined.
interface iir_coef_sequencer_if #(
    parameter int COEF_W = 32
) ();
    logic              wr_en;
    logic [2:0]        wr_addr;
    logic [COEF_W-1:0] wr_data;
    logic              wr_err;
    logic              commit;
    logic              run_en;
    logic              busy;
    logic              done;
    logic              cfg_valid;
    logic [2:0]        reg_select;
    logic              enable_reg_select;
    logic [COEF_W-1:0] coefficient;
    logic              n_1_reset;
    logic              filter_enable;
`ifdef COEF_READBACK_EN
    logic [2:0]        rd_addr;
    logic              rd_sel;
    logic [COEF_W-1:0] rd_data;
`endif

    modport master (
        output wr_en, wr_addr, wr_data, commit, run_en,
`ifdef COEF_READBACK_EN
        output rd_addr, rd_sel,
        input  rd_data,
`endif
        input  wr_err, busy, done, cfg_valid, reg_select, enable_reg_select,
        input  coefficient, n_1_reset, filter_enable
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, commit, run_en,
`ifdef COEF_READBACK_EN
        input  rd_addr, rd_sel,
        output rd_data,
`endif
        output wr_err, busy, done, cfg_valid, reg_select, enable_reg_select,
        output coefficient, n_1_reset, filter_enable
    );
endinterface

// File: rtl/iir_coef_sequencer.sv
// rtl/iir_coef_sequencer.sv - shadows five biquad coefficients, loads a committed snapshot, flushes history, enables filter
// Define COEF_READBACK_EN to add registered shadow/snapshot readback (rd_addr, rd_sel, rd_data).
module iir_coef_sequencer #(
    parameter int FLUSH_CYCLES = 2,
    parameter int COEF_W       = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    iir_coef_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_RUN
    } state_t;

    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
    localparam logic [3:0] LOAD_LAST  = 4'd4;

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic              pending_q;
    logic [COEF_W-1:0] shadow_q   [5];
    logic [COEF_W-1:0] shadow_d   [5];
    logic [COEF_W-1:0] snapshot_q [5];

    logic              wr_err_q;
    logic              busy_q;
    logic              done_q;
    logic              cfg_valid_q;
    logic [2:0]        reg_select_q;
    logic              enable_reg_select_q;
    logic [COEF_W-1:0] coefficient_q;
    logic              n_1_reset_q;
    logic              filter_enable_q;
`ifdef COEF_READBACK_EN
    logic [COEF_W-1:0] rd_data_q;
`endif

    // A same-edge write must be visible to a commit snapshot, so the snapshot takes shadow_d.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            shadow_d[i] = shadow_q[i];
        end
        if (bus.wr_en && (bus.wr_addr <= 3'd4)) begin
            shadow_d[bus.wr_addr] = bus.wr_data;
        end
    end

    // State runs one edge ahead of the registered filter-side outputs it produces.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q             <= S_IDLE;
            cnt_q               <= '0;
            pending_q           <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                shadow_q[i]   <= '0;
                snapshot_q[i] <= '0;
            end
            wr_err_q            <= 1'b0;
            busy_q              <= 1'b0;
            done_q              <= 1'b0;
            cfg_valid_q         <= 1'b0;
            reg_select_q        <= '0;
            enable_reg_select_q <= 1'b0;
            coefficient_q       <= '0;
            n_1_reset_q         <= 1'b0;
            filter_enable_q     <= 1'b0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
            wr_err_q            <= bus.wr_en && (bus.wr_addr > 3'd4);
            busy_q              <= 1'b0;
            done_q              <= 1'b0;
            reg_select_q        <= '0;
            enable_reg_select_q <= 1'b0;
            coefficient_q       <= '0;
            n_1_reset_q         <= 1'b0;
            filter_enable_q     <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (bus.commit) begin
                        state_q <= S_LOAD;
                        cnt_q   <= '0;
                        for (int i = 0; i < 5; i++) begin
                            snapshot_q[i] <= shadow_d[i];
                        end
                    end
                end
                S_LOAD: begin
                    busy_q              <= 1'b1;
                    cfg_valid_q         <= 1'b0;
                    enable_reg_select_q <= 1'b1;
                    reg_select_q        <= cnt_q[2:0];
                    coefficient_q       <= snapshot_q[cnt_q[2:0]];
                    if (bus.commit) begin
                        pending_q <= 1'b1;
                    end
                    if (cnt_q == LOAD_LAST) begin
                        state_q <= S_FLUSH;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_FLUSH: begin
                    busy_q      <= 1'b1;
                    n_1_reset_q <= 1'b1;
                    if (bus.commit) begin
                        pending_q <= 1'b1;
                    end
                    if (cnt_q == FLUSH_LAST) begin
                        state_q <= S_RUN;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_RUN: begin
                    // cfg_valid is still low only on the first RUN edge, which is the done edge.
                    if (!cfg_valid_q) begin
                        done_q      <= 1'b1;
                        cfg_valid_q <= 1'b1;
                    end
                    filter_enable_q <= bus.run_en && cfg_valid_q;
                    if (bus.commit || pending_q) begin
                        state_q   <= S_LOAD;
                        cnt_q     <= '0;
                        pending_q <= 1'b0;
                        for (int i = 0; i < 5; i++) begin
                            snapshot_q[i] <= shadow_d[i];
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

`ifdef COEF_READBACK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (bus.rd_addr > 3'd4) begin
            rd_data_q <= '0;
        end else if (bus.rd_sel) begin
            rd_data_q <= snapshot_q[bus.rd_addr];
        end else begin
            rd_data_q <= shadow_q[bus.rd_addr];
        end
    end

    assign bus.rd_data = rd_data_q;
`endif

    assign bus.wr_err            = wr_err_q;
    assign bus.busy              = busy_q;
    assign bus.done              = done_q;
    assign bus.cfg_valid         = cfg_valid_q;
    assign bus.reg_select        = reg_select_q;
    assign bus.enable_reg_select = enable_reg_select_q;
    assign bus.coefficient       = coefficient_q;
    assign bus.n_1_reset         = n_1_reset_q;
    assign bus.filter_enable     = filter_enable_q;
endmodule

// File: tb/tb_iir_coef_sequencer.sv
// tb/tb_iir_coef_sequencer.sv - directed vector bench for iir_coef_sequencer
module tb_iir_coef_sequencer;
    localparam int COEF_W = 32;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    iir_coef_sequencer_if #(.COEF_W(COEF_W)) bus ();

    iir_coef_sequencer #(
        .FLUSH_CYCLES(2),
        .COEF_W      (COEF_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr_en;
        logic [2:0]  wr_addr;
        logic [31:0] wr_data;
        logic        commit;
        logic        run_en;
        logic        e_ers;
        logic [2:0]  e_sel;
        logic [31:0] e_coef;
        logic        e_n1r;
        logic        e_busy;
        logic        e_done;
        logic        e_cfg;
        logic        e_fe;
        logic        e_err;
    } vec_t;

    vec_t vq[$];

    task automatic tick();
        @(posedge clk);
        #1;
        done_cnt += int'(bus.done);
    endtask

    task automatic drive(input logic we, input logic [2:0] a, input logic [31:0] d,
                         input logic cm, input logic re);
        bus.wr_en   = we;
        bus.wr_addr = a;
        bus.wr_data = d;
        bus.commit  = cm;
        bus.run_en  = re;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic ers, input logic [2:0] sel,
                            input logic [31:0] coef, input logic n1r, input logic busy,
                            input logic done, input logic cfg, input logic fe, input logic err);
        chk({tag, " enable_reg_select"}, 32'(bus.enable_reg_select), 32'(ers));
        chk({tag, " reg_select"},        32'(bus.reg_select),        32'(sel));
        chk({tag, " coefficient"},       bus.coefficient,            coef);
        chk({tag, " n_1_reset"},         32'(bus.n_1_reset),         32'(n1r));
        chk({tag, " busy"},              32'(bus.busy),              32'(busy));
        chk({tag, " done"},              32'(bus.done),              32'(done));
        chk({tag, " cfg_valid"},         32'(bus.cfg_valid),         32'(cfg));
        chk({tag, " filter_enable"},     32'(bus.filter_enable),     32'(fe));
        chk({tag, " wr_err"},            32'(bus.wr_err),            32'(err));
    endtask

    task automatic add(input logic we, input logic [2:0] a, input logic [31:0] d,
                       input logic cm, input logic re, input logic ers, input logic [2:0] sel,
                       input logic [31:0] coef, input logic n1r, input logic busy,
                       input logic done, input logic cfg, input logic fe, input logic err);
        vec_t v;
        v = '{we, a, d, cm, re, ers, sel, coef, n1r, busy, done, cfg, fe, err};
        vq.push_back(v);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
`ifdef COEF_READBACK_EN
        bus.rd_addr = 3'd0;
        bus.rd_sel  = 1'b0;
`endif

        // writes, illegal write, commit, load 0..4, flush x2, done, then run_en on/off
        //   we    addr  data          cm    re    ers   sel   coef          n1r   busy  done  cfg   fe    err
        add(1'b1, 3'd0, 32'h00010000, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'd1, 32'h1,        1'b0, 1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'd2, 32'h2,        1'b0, 1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'd3, 32'h3,        1'b0, 1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'd4, 32'h4,        1'b0, 1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'd6, 32'hDEAD,     1'b0, 1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 3'd0, 32'h0,        1'b1, 1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b1, 3'd0, 32'h00010000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b1, 3'd1, 32'h1,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b1, 3'd2, 32'h2,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b1, 3'd3, 32'h3,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b1, 3'd4, 32'h4,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b0, 3'd0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b0, 3'd0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 3'd0, 32'h0,        1'b0, 1'b1, 1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 3'd0, 32'h0,        1'b0, 1'b1, 1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        tick();
        tick();
        chk_outs("reset", 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        foreach (vq[i]) begin
            drive(vq[i].wr_en, vq[i].wr_addr, vq[i].wr_data, vq[i].commit, vq[i].run_en);
            tick();
            chk_outs($sformatf("row%0d", i), vq[i].e_ers, vq[i].e_sel, vq[i].e_coef, vq[i].e_n1r,
                     vq[i].e_busy, vq[i].e_done, vq[i].e_cfg, vq[i].e_fe, vq[i].e_err);
        end

        // Commit, rewrite n1 mid-load, commit again in the third load cycle.
        done_cnt = 0;
        drive(1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
        tick();
        chk_outs("pend ld0", 1'b1, 3'd0, 32'h00010000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'd0, 32'h5, 1'b0, 1'b0);
        tick();
        chk_outs("pend ld1", 1'b1, 3'd1, 32'h1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
        tick();
        chk_outs("pend ld2", 1'b1, 3'd2, 32'h2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
        tick();
        chk_outs("pend ld3", 1'b1, 3'd3, 32'h3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
        tick();
        chk_outs("pend ld4", 1'b1, 3'd4, 32'h4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk_outs("pend fl1", 1'b0, 3'd0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_outs("pend done1", 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_outs("pend re-ld0", 1'b1, 3'd0, 32'h5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 5; i++) begin
            tick();
            chk_outs($sformatf("pend re-ld%0d", i), 1'b1, 3'(i), 32'(i), 1'b0, 1'b1,
                     1'b0, 1'b0, 1'b0, 1'b0);
        end
        tick();
        tick();
        tick();
        chk_outs("pend done2", 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        chk_outs("pend settled", 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("pend done count", 32'(done_cnt), 32'd2);

`ifdef COEF_READBACK_EN
        drive(1'b1, 3'd4, 32'h7, 1'b0, 1'b0);
        tick();
        drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
        bus.rd_addr = 3'd4;
        bus.rd_sel  = 1'b0;
        tick();
        chk("rd shadow d2", bus.rd_data, 32'h7);
        bus.rd_sel = 1'b1;
        tick();
        chk("rd snapshot d2", bus.rd_data, 32'h4);
        bus.rd_addr = 3'd0;
        tick();
        chk("rd snapshot n1", bus.rd_data, 32'h5);
        bus.rd_addr = 3'd6;
        tick();
        chk("rd illegal addr", bus.rd_data, 32'h0);
        bus.rd_addr = 3'd0;
        bus.rd_sel  = 1'b0;
`endif

        // Reset in the first flush cycle aborts with no done.
        drive(1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        chk_outs("abort flush", 1'b0, 3'd0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        chk_outs("abort reset", 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset    = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        chk_outs("abort idle", 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort done count", 32'(done_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
